// File: rtl/sigmoid_lane_scheduler.sv
// Two-lane round-robin issue scheduler for a pipelined sigmoid engine.
// Tracks lane ownership through a tag pipe and returns results in issue order via a FIFO.
module sigmoid_lane_scheduler #(
  parameter int NREQ       = 4,
  parameter int ENG_LAT    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [16*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic signed [15:0]        eng_x0,
  output logic signed [15:0]        eng_x1,
  output logic                      eng_valid,
  input  logic signed [15:0]        eng_y0,
  input  logic signed [15:0]        eng_y1,
  input  logic                      eng_valid_out,
  output logic                      rsp_v0,
  output logic                      rsp_v1,
  output logic [$clog2(NREQ)-1:0]   rsp_id0,
  output logic [$clog2(NREQ)-1:0]   rsp_id1,
  output logic signed [15:0]        rsp_y0,
  output logic signed [15:0]        rsp_y1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      err
);

  localparam int DATA_W = 16;
  localparam int IDW    = $clog2(NREQ);
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int NST    = ENG_LAT + 1;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [IDW-1:0]           rr_ptr;
  logic                     g0, g1;
  logic [IDW-1:0]           sel0, sel1;
  logic signed [DATA_W-1:0] samp0, samp1;
  logic [31:0]              inflight;
  logic                     issue_ok;

  logic [NST-1:0]           tag_v0, tag_v1;
  logic [IDW-1:0]           tag_id0 [NST];
  logic [IDW-1:0]           tag_id1 [NST];
  logic                     last_vld;

  logic                     fifo_v0  [FIFO_DEPTH];
  logic                     fifo_v1  [FIFO_DEPTH];
  logic [IDW-1:0]           fifo_id0 [FIFO_DEPTH];
  logic [IDW-1:0]           fifo_id1 [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_y0  [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_y1  [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            fifo_count;
  logic                     full, push, pop;

  // Occupancy: everything issued and not yet popped, so the FIFO can never overflow
  always_comb begin
    inflight = '0;
    for (int s = 0; s < NST; s++) inflight = inflight + 32'(tag_v0[s]);
  end

  assign issue_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);

  // Arbitration: lane0 from rr_ptr, lane1 the next distinct requester after lane0
  always_comb begin
    g0   = 1'b0;
    g1   = 1'b0;
    sel0 = '0;
    sel1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!g0 && req_valid[wrap_idx(rr_ptr, k)]) begin
        g0   = 1'b1;
        sel0 = wrap_idx(rr_ptr, k);
      end
    end
    for (int k = 1; k < NREQ; k++) begin
      if (g0 && !g1 && req_valid[wrap_idx(sel0, k)]) begin
        g1   = 1'b1;
        sel1 = wrap_idx(sel0, k);
      end
    end
    if (!issue_ok) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (g0) req_ready[sel0] = 1'b1;
    if (g1) req_ready[sel1] = 1'b1;
    if (!rst_n) req_ready = '0;
  end

  assign samp0 = req_data[DATA_W*sel0 +: DATA_W];
  assign samp1 = req_data[DATA_W*sel1 +: DATA_W];

  // Stage boundary: engine input registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_valid <= 1'b0;
      eng_x0    <= '0;
      eng_x1    <= '0;
      rr_ptr    <= '0;
    end else begin
      eng_valid <= g0;
      if (g0) begin
        eng_x0 <= samp0;
        eng_x1 <= g1 ? samp1 : '0;
        rr_ptr <= wrap_idx(g1 ? sel1 : sel0, 1);
      end
    end
  end

  // Stage boundary: tag pipe aligned with the engine's latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v0 <= '0;
      tag_v1 <= '0;
      for (int s = 0; s < NST; s++) begin
        tag_id0[s] <= '0;
        tag_id1[s] <= '0;
      end
    end else begin
      tag_v0     <= {tag_v0[NST-2:0], g0};
      tag_v1     <= {tag_v1[NST-2:0], g1};
      tag_id0[0] <= sel0;
      tag_id1[0] <= sel1;
      for (int s = 1; s < NST; s++) begin
        tag_id0[s] <= tag_id0[s-1];
        tag_id1[s] <= tag_id1[s-1];
      end
    end
  end

  assign last_vld = tag_v0[NST-1];
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign pop      = rsp_valid && rsp_ready;
  assign push     = last_vld && (!full || pop);

  // Stage boundary: result FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
      if ((eng_valid_out != last_vld) || (last_vld && full && !pop)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_v0[wr_ptr]  <= tag_v0[NST-1];
      fifo_id0[wr_ptr] <= tag_id0[NST-1];
      fifo_y0[wr_ptr]  <= eng_y0;
      fifo_v1[wr_ptr]  <= tag_v1[NST-1];
      fifo_id1[wr_ptr] <= tag_id1[NST-1];
      fifo_y1[wr_ptr]  <= eng_y1;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_v0    = rsp_valid && fifo_v0[rd_ptr];
  assign rsp_v1    = rsp_valid && fifo_v1[rd_ptr];
  assign rsp_id0   = fifo_id0[rd_ptr];
  assign rsp_id1   = fifo_id1[rd_ptr];
  assign rsp_y0    = fifo_y0[rd_ptr];
  assign rsp_y1    = fifo_y1[rd_ptr];

endmodule

// File: tb/tb_sigmoid_lane_scheduler.sv
// Bench for sigmoid_lane_scheduler: engine stand-in plus a queue-based model of
// arbitration, occupancy and in-order result delivery.
module tb_sigmoid_lane_scheduler;

  localparam int NREQ       = 4;
  localparam int ENG_LAT    = 3;
  localparam int FIFO_DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [15:0]          eng_x0, eng_x1, eng_y0, eng_y1;
  logic                 eng_valid, eng_valid_out;
  logic                 rsp_v0, rsp_v1, rsp_valid, rsp_ready, err;
  logic [1:0]           rsp_id0, rsp_id1;
  logic [15:0]          rsp_y0, rsp_y1;

  always #5 clk = ~clk;

  sigmoid_lane_scheduler #(.NREQ(NREQ), .ENG_LAT(ENG_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_valid(eng_valid),
    .eng_y0(eng_y0), .eng_y1(eng_y1), .eng_valid_out(eng_valid_out),
    .rsp_v0(rsp_v0), .rsp_v1(rsp_v1), .rsp_id0(rsp_id0), .rsp_id1(rsp_id1),
    .rsp_y0(rsp_y0), .rsp_y1(rsp_y1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .err(err)
  );

  // Engine stand-in: a few true sigmoid points, an arbitrary bijection elsewhere
  function automatic logic [15:0] eng_f(input logic [15:0] x);
    case (x)
      16'h0000: return 16'd1024;
      16'h0800: return 16'd1498;
      16'hF800: return 16'd550;
      default:  return x ^ 16'h5A3C;
    endcase
  endfunction

  logic        ev  [ENG_LAT];
  logic [15:0] ey0 [ENG_LAT];
  logic [15:0] ey1 [ENG_LAT];
  logic        force_evo = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENG_LAT; i++) ev[i] <= 1'b0;
    end else begin
      ev[0]  <= eng_valid;
      ey0[0] <= eng_f(eng_x0);
      ey1[0] <= eng_f(eng_x1);
      for (int i = 1; i < ENG_LAT; i++) begin
        ev[i]  <= ev[i-1];
        ey0[i] <= ey0[i-1];
        ey1[i] <= ey1[i-1];
      end
    end
  end

  assign eng_valid_out = force_evo | ev[ENG_LAT-1];
  assign eng_y0 = ey0[ENG_LAT-1];
  assign eng_y1 = ey1[ENG_LAT-1];

  typedef struct {
    int          id0;
    logic [15:0] y0;
    bit          v1;
    int          id1;
    logic [15:0] y1;
    int          rdy;
  } ent_t;

  ent_t            q[$];
  int              rr_m = 0;
  int              edge_n = 0;
  bit              err_exp = 1'b0;
  int              errors = 0;
  int              checks = 0;
  logic [NREQ-1:0] last_rdy;
  int              dut_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void arb(input logic [NREQ-1:0] v, output int a, output int b);
    a = -1;
    b = -1;
    for (int k = 0; k < NREQ; k++)
      if (a < 0 && v[(rr_m + k) % NREQ]) a = (rr_m + k) % NREQ;
    if (a >= 0)
      for (int k = 1; k < NREQ; k++)
        if (b < 0 && v[(a + k) % NREQ]) b = (a + k) % NREQ;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model at posedge
  task automatic step(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] d, input logic rr);
    int a, b;
    logic [NREQ-1:0] er;
    bit avail;
    ent_t e;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    a = -1;
    b = -1;
    if (q.size() < FIFO_DEPTH) arb(v, a, b);
    er = '0;
    if (a >= 0) er[a] = 1'b1;
    if (b >= 0) er[b] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    avail = (q.size() > 0) && (q[0].rdy <= edge_n);
    chk("rsp_valid", 32'(rsp_valid), 32'(avail));
    if (avail) begin
      chk("rsp_v0", 32'(rsp_v0), 32'd1);
      chk("rsp_id0", 32'(rsp_id0), 32'(q[0].id0));
      chk("rsp_y0", 32'(rsp_y0), 32'(q[0].y0));
      chk("rsp_v1", 32'(rsp_v1), 32'(q[0].v1));
      if (q[0].v1) begin
        chk("rsp_id1", 32'(rsp_id1), 32'(q[0].id1));
        chk("rsp_y1", 32'(rsp_y1), 32'(q[0].y1));
      end
    end else begin
      chk("rsp_v0_idle", 32'(rsp_v0), 32'd0);
      chk("rsp_v1_idle", 32'(rsp_v1), 32'd0);
    end
    chk("err", 32'(err), 32'(err_exp));
    last_rdy = req_ready;
    if (rsp_valid && rr) dut_pops++;
    @(posedge clk);
    if (avail && rr) void'(q.pop_front());
    edge_n++;
    if (a >= 0) begin
      e.id0 = a;
      e.y0  = eng_f(d[16*a +: 16]);
      e.v1  = (b >= 0);
      e.id1 = (b >= 0) ? b : 0;
      e.y1  = (b >= 0) ? eng_f(d[16*b +: 16]) : 16'h0;
      e.rdy = edge_n + ENG_LAT + 1;
      q.push_back(e);
      rr_m = (((b >= 0) ? b : a) + 1) % NREQ;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_eng_valid", 32'(eng_valid), 32'd0);
    chk("rst_eng_x0", 32'(eng_x0), 32'd0);
    chk("rst_eng_x1", 32'(eng_x1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    rr_m    = 0;
    err_exp = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [NREQ-1:0] rec [6];
    logic [16*NREQ-1:0] d;
    logic [NREQ-1:0] v;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #2;
    do_reset();

    // Single requester 2 with x=0
    step(4'b0100, '0, 1'b0);
    chk("single_eng_valid", 32'(eng_valid), 32'd1);
    chk("single_eng_x1", 32'(eng_x1), 32'd0);
    repeat (3) step('0, '0, 1'b0);
    chk("single_not_yet", 32'(rsp_valid), 32'd0);
    step('0, '0, 1'b0);
    chk("single_rsp_v0", 32'(rsp_v0), 32'd1);
    chk("single_rsp_id0", 32'(rsp_id0), 32'd2);
    chk("single_rsp_y0", 32'(rsp_y0), 32'd1024);
    chk("single_rsp_v1", 32'(rsp_v1), 32'd0);
    repeat (3) step('0, '0, 1'b1);

    // Requesters 0 and 3 in the same cycle from rr_ptr=0
    do_reset();
    d = {16'hF800, 16'h0000, 16'h0000, 16'h0800};
    step(4'b1001, d, 1'b0);
    chk("pair_eng_x0", 32'(eng_x0), 32'h0800);
    chk("pair_eng_x1", 32'(eng_x1), 32'hF800);
    repeat (4) step('0, '0, 1'b0);
    chk("pair_rsp_id0", 32'(rsp_id0), 32'd0);
    chk("pair_rsp_y0", 32'(rsp_y0), 32'd1498);
    chk("pair_rsp_v1", 32'(rsp_v1), 32'd1);
    chk("pair_rsp_id1", 32'(rsp_id1), 32'd3);
    chk("pair_rsp_y1", 32'(rsp_y1), 32'd550);
    repeat (2) step('0, '0, 1'b1);

    // All four requesting with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      step('1, {$urandom(), $urandom()}, 1'b1);
      rec[i] = last_rdy;
    end
    chk("rr_pair0", 32'(rec[0]), 32'h3);
    chk("rr_pair1", 32'(rec[1]), 32'hC);
    chk("rr_pair2", 32'(rec[2]), 32'h3);
    chk("rr_pair5", 32'(rec[5]), 32'hC);
    repeat (12) step('0, '0, 1'b1);

    // Backpressure: consumer stalled until the FIFO budget is exhausted
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step('1, {$urandom(), $urandom()}, 1'b0);
      if (last_rdy != '0) cnt++;
    end
    chk("full_issue_cycles", 32'(cnt), 32'd8);
    chk("full_req_ready", 32'(last_rdy), 32'd0);
    dut_pops = 0;
    repeat (12) step('0, '0, 1'b1);
    chk("drain_pops", 32'(dut_pops), 32'd8);

    // Reset with three pairs in flight and two queued
    repeat (5) step('1, {$urandom(), $urandom()}, 1'b0);
    step('0, '0, 1'b0);
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    do_reset();
    step('1, {$urandom(), $urandom()}, 1'b1);
    chk("post_reset_grant", 32'(last_rdy), 32'h3);
    repeat (12) step('0, '0, 1'b1);

    // Randomized traffic, first with a mostly-ready consumer then a mostly-stalled one
    for (int i = 0; i < 400; i++) begin
      v = NREQ'($urandom());
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) d[15:0] = 16'h0800;
      if ($urandom_range(0, 7) == 0) d[31:16] = 16'hF800;
      step(v, d, (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    repeat (20) step('0, '0, 1'b1);
    chk("drained_empty", 32'(rsp_valid), 32'd0);

    // Engine valid with nothing in flight
    force_evo = 1'b1;
    step('0, '0, 1'b1);
    force_evo = 1'b0;
    err_exp   = 1'b1;
    repeat (3) step('0, '0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
